// File: rtl/ysyx_25020032_clint_if.sv
// ysyx_25020032_clint_if: AXI4 bus between the crossbar (master) and the CLINT timer (slave).
// Carries the AR/R/AW/W/B channels with 4-bit IDs and 32-bit data.
interface ysyx_25020032_clint_if;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  modport master (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
           s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
           s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
           s_awready, s_wready, s_bid, s_bresp, s_bvalid
  );
  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
           s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
           s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
           s_awready, s_wready, s_bid, s_bresp, s_bvalid
  );
endinterface

// File: rtl/ysyx_25020032_clint.sv
// ysyx_25020032_clint: AXI4 slave exposing a 64-bit mtime counter at BASE (low) / BASE+4 (high).
// Ports: clk; rst (async, active-low); s (AXI4 slave modport); mtime_o (live counter).
module ysyx_25020032_clint #(
  parameter int unsigned DIV  = 1,
  parameter logic [31:0] BASE = 32'ha0000048
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25020032_clint_if.slave        s,
  output logic [63:0]                 mtime_o
);
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [31:0] BASE_HI = BASE + 32'd4;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] pre_q, pre_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        shadow_v_q, shadow_v_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        rbad_q, rbad_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  wid_q, wid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d;
  logic [8:0]  wcnt_q, wcnt_d;
  logic        wbad_q, wbad_d;
  logic        berr_q, berr_d;
  logic        tick, ar_hs, r_hs, r_cap, cap_bad, cap_lo, cap_hi;
  logic [31:0] cap_addr, cap_data, wmask;
  logic        aw_hs, w_hs, w_lo, w_hi, w_hit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state_q   <= R_IDLE;
      w_state_q   <= W_IDLE;
      mtime_q     <= '0;
      pre_q       <= '0;
      hi_shadow_q <= '0;
      shadow_v_q  <= 1'b0;
      rid_q       <= '0;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rcnt_q      <= '0;
      rbad_q      <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      wid_q       <= '0;
      waddr_q     <= '0;
      wlen_q      <= '0;
      wcnt_q      <= '0;
      wbad_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      w_state_q   <= w_state_d;
      mtime_q     <= mtime_d;
      pre_q       <= pre_d;
      hi_shadow_q <= hi_shadow_d;
      shadow_v_q  <= shadow_v_d;
      rid_q       <= rid_d;
      raddr_q     <= raddr_d;
      rlen_q      <= rlen_d;
      rcnt_q      <= rcnt_d;
      rbad_q      <= rbad_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      wid_q       <= wid_d;
      waddr_q     <= waddr_d;
      wlen_q      <= wlen_d;
      wcnt_q      <= wcnt_d;
      wbad_q      <= wbad_d;
      berr_q      <= berr_d;
    end
  // Next-state and datapath. Read beats are captured from the pre-update mtime_q,
  // so a same-cycle write is never visible to the read launched on that edge.
  always_comb begin
    tick        = pre_q == DIV_M1;
    ar_hs       = s.s_arvalid && r_state_q == R_IDLE;
    r_hs        = s.s_rready && r_state_q == R_DATA;
    r_cap       = ar_hs || (r_hs && !rlast_q);
    cap_addr    = ar_hs ? s.s_araddr : raddr_q + 32'd4;
    cap_bad     = ar_hs ? (s.s_arsize != 3'd2 || s.s_arburst != 2'b01) : rbad_q;
    cap_lo      = !cap_bad && cap_addr == BASE;
    cap_hi      = !cap_bad && cap_addr == BASE_HI;
    cap_data    = cap_lo ? mtime_q[31:0] : cap_hi ? (shadow_v_q ? hi_shadow_q : mtime_q[63:32]) : 32'd0;
    r_state_d   = ar_hs ? R_DATA : (r_hs && rlast_q) ? R_IDLE : r_state_q;
    rid_d       = ar_hs ? s.s_arid : rid_q;
    rlen_d      = ar_hs ? s.s_arlen : rlen_q;
    rbad_d      = r_cap ? cap_bad : rbad_q;
    raddr_d     = r_cap ? cap_addr : raddr_q;
    rcnt_d      = ar_hs ? 8'd0 : r_cap ? rcnt_q + 8'd1 : rcnt_q;
    rlast_d     = ar_hs ? s.s_arlen == 8'd0 : r_cap ? rcnt_q + 8'd1 == rlen_q : rlast_q;
    rdata_d     = r_cap ? cap_data : rdata_q;
    rresp_d     = r_cap ? ((cap_lo || cap_hi) ? 2'b00 : 2'b10) : rresp_q;
    aw_hs       = s.s_awvalid && w_state_q == W_IDLE;
    w_hs        = s.s_wvalid && w_state_q == W_DATA;
    w_lo        = w_hs && !wbad_q && waddr_q == BASE;
    w_hi        = w_hs && !wbad_q && waddr_q == BASE_HI;
    w_hit       = w_lo || w_hi;
    wmask       = {{8{s.s_wstrb[3]}}, {8{s.s_wstrb[2]}}, {8{s.s_wstrb[1]}}, {8{s.s_wstrb[0]}}};
    w_state_d   = aw_hs ? W_DATA : (w_hs && s.s_wlast) ? W_RESP : (w_state_q == W_RESP && s.s_bready) ? W_IDLE : w_state_q;
    wid_d       = aw_hs ? s.s_awid : wid_q;
    wlen_d      = aw_hs ? s.s_awlen : wlen_q;
    wbad_d      = aw_hs ? (s.s_awsize != 3'd2 || s.s_awburst != 2'b01) : wbad_q;
    waddr_d     = aw_hs ? s.s_awaddr : w_hs ? waddr_q + 32'd4 : waddr_q;
    wcnt_d      = aw_hs ? 9'd0 : w_hs ? wcnt_q + 9'd1 : wcnt_q;
    berr_d      = aw_hs ? 1'b0 : w_hs ? (berr_q || !w_hit || (s.s_wlast && wcnt_q != {1'b0, wlen_q})) : berr_q;
    // A software write owns the counter for its cycle: no increment, prescaler restarts.
    mtime_d     = w_lo ? {mtime_q[63:32], (mtime_q[31:0] & ~wmask) | (s.s_wdata & wmask)} :
                  w_hi ? {(mtime_q[63:32] & ~wmask) | (s.s_wdata & wmask), mtime_q[31:0]} :
                  tick ? mtime_q + 64'd1 : mtime_q;
    pre_d       = (w_hit || tick) ? 16'd0 : pre_q + 16'd1;
    // A low-word read freezes the high word so a following high read is tear-free;
    // a write invalidates the snapshot since it no longer matches the counter.
    hi_shadow_d = (r_cap && cap_lo) ? mtime_q[63:32] : hi_shadow_q;
    shadow_v_d  = w_hit ? 1'b0 : (r_cap && cap_lo) ? 1'b1 : (r_cap && cap_hi) ? 1'b0 : shadow_v_q;
  end
  always_comb begin
    s.s_arready = r_state_q == R_IDLE;
    s.s_rvalid  = r_state_q == R_DATA;
    s.s_rid     = rid_q;
    s.s_rdata   = rdata_q;
    s.s_rresp   = rresp_q;
    s.s_rlast   = rlast_q;
    s.s_awready = w_state_q == W_IDLE;
    s.s_wready  = w_state_q == W_DATA;
    s.s_bvalid  = w_state_q == W_RESP;
    s.s_bid     = wid_q;
    s.s_bresp   = berr_q ? 2'b10 : 2'b00;
    mtime_o     = mtime_q;
  end
endmodule

// File: doc/ysyx_25020032_clint.md
# ysyx_25020032_clint

AXI4 responder implementing the core-local timer (64-bit `mtime`) at 0xa0000048–0xa000004f, the subordinate behind the crossbar's CLINT port. It accepts AXI4 INCR read/write bursts, returns registered responses with echoed IDs, and supports software writes to `mtime`. A high-word shadow gives software a tear-free 64-bit read when it reads the low word then the high word.

## Interface
- `DIV`, default 1: `mtime` increments once every `DIV` clocks; legal range 1..65535.
- `BASE`, default 32'ha0000048: address of `mtime[31:0]`; `BASE+4` is `mtime[63:32]`.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_arid` in 4, `s_araddr` in 32, `s_arlen` in 8, `s_arsize` in 3, `s_arburst` in 2, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rid` out 4, `s_rdata` out 32, `s_rresp` out 2, `s_rlast` out 1, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `s_awid` in 4, `s_awaddr` in 32, `s_awlen` in 8, `s_awsize` in 3, `s_awburst` in 2, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wlast` in 1, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bid` out 4, `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `mtime_o`  out  64  live counter value, for the core's timer-interrupt compare.

## Operation
- Counter: 16-bit prescaler counts 0..DIV-1; `mtime` += 1 on the cycle the prescaler equals DIV-1, wrapping at 2^64-1 → 0. A write beat hitting a word replaces the bytes selected by `s_wstrb`; the increment is suppressed for that cycle and the prescaler resets to 0.
- Read FSM: R_IDLE → R_DATA.
  - R_IDLE: `s_arready`=1. On AR handshake, latch id, address, len; compute beat 0; → R_DATA.
  - R_DATA: `s_rvalid`=1, `s_rdata`/`s_rresp`/`s_rlast` stable until `s_rready`. On handshake: if last → R_IDLE, else next beat (address += 4) presented next cycle.
- Beat decode (reads and writes): `BASE` → low word, `BASE+4` → high word, anything else → data 0, resp SLVERR (2'b10). `s_arsize`/`s_awsize` other than 2, or burst type other than INCR (2'b01), → SLVERR for every beat. OKAY = 2'b00.
- Shadow: a read beat of the low word latches `mtime[63:32]` into `hi_shadow` and sets `shadow_v`. A high-word read returns `hi_shadow` if `shadow_v`, else the live value; either way it clears `shadow_v`. A write to either word clears `shadow_v`.
- Write FSM: W_IDLE → W_DATA → W_RESP.
  - W_IDLE: `s_awready`=1, `s_wready`=0. On AW handshake → W_DATA.
  - W_DATA: `s_wready`=1; each W handshake performs one beat, address += 4. On a beat with `s_wlast`=1 → W_RESP. A beat count ≠ awlen+1 at wlast → SLVERR.
  - W_RESP: `s_bvalid`=1, `s_bid`=latched awid, `s_bresp`=OKAY unless any beat erred. On `s_bready` → W_IDLE.
- Read and write FSMs run independently. A write and a read in the same cycle: the read samples the pre-write `mtime`.

## Timing
- Reset (rst=0, async): `mtime`=0, prescaler=0, `shadow_v`=0, both FSMs idle. Outputs: `s_arready`=1, `s_awready`=1, `s_wready`=0, `s_rvalid`=0, `s_bvalid`=0, `s_rdata`=0, `s_rid`=0, `s_rresp`=0, `s_rlast`=0, `s_bid`=0, `s_bresp`=0, `mtime_o`=0.
- Read latency: AR handshake at edge T → `s_rvalid` high after T. With `s_rready` held high, beats are back-to-back, one per cycle. Read data is captured at the edge that launches the beat.
- Write: AW at edge T → `s_wready` after T. Last W at edge U → `s_bvalid` after U. Minimum AW-to-B is 2 cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Reset asserted mid-burst aborts the transaction immediately. No response is owed after reset.

## Test plan
- DIV=1, reset release, idle 10 cycles, then single read at 0xa0000048 → `s_rdata` equals the cycle count at AR handshake, rresp 00, rlast 1, rid echoes arid=4'h5.
- Write 0xffffffff to low and 0x00000000 to high with DIV=1, then read 4-beat-ago high → carry into high observed; `mtime` 0xffffffff_ffffffff wraps to 0.
- Shadow: set `mtime`=0x00000000_fffffffe, read low (0xfffffffe), stall 5 cycles, read high → 0x00000000, not 0x00000001.
- 2-beat INCR read at 0xa0000048 with `s_rready` toggled every other cycle → data held stable while stalled; beat1 is the high word; rlast only on beat1.
- Read 0xa0000050 and write with awsize=1 → rresp 10 with data 0; bresp 10 with `mtime` unchanged.
- Partial write `s_wstrb`=4'b0001, wdata 0x000000AA to low with DIV=4 → only byte 0 changes, prescaler restarts, next increment 4 cycles later.
